fc2_argmax_layer: RTL and testbench

- Final classifier stage. Sits directly downstream of the 48->16 fully-connected layer and consumes its 16 ReLU'd 16-bit activations.
- Performs a 16->10 signed 8-bit-weight fully-connected layer with bias, then an argmax over the 10 class scores.
- Emits the winning class index and its score with a one-cycle valid pulse.
- Weights and biases stream in serially after reset, one byte per cycle.

---
 rtl/fc2_argmax_layer_pkg.sv | 26 ++
 rtl/fc2_argmax_layer_argmax_seq.sv | 45 ++++
 rtl/fc2_argmax_layer.sv | 140 ++++++++++++++
 tb/tb_fc2_argmax_layer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fc2_argmax_layer_pkg.sv
// Shared sizing, weight-stream bookkeeping and FSM encoding for the 16->10
// classifier layer and its argmax stage.
package fc2_argmax_layer_pkg;

   localparam int IN_NUM     = 16;
   localparam int OUT_NUM    = 10;
   localparam int IN_W       = 16;
   localparam int W_W        = 8;
   localparam int ACC_W      = 28;
   localparam int BIAS_SHIFT = 8;
   localparam int PROD_W     = IN_W + W_W;

   localparam int W_NUM      = IN_NUM * OUT_NUM;
   localparam int WB_TOTAL   = W_NUM + OUT_NUM;
   localparam int CNT_W      = 10;
   localparam int WIDX_W     = 8;
   localparam int IDX_W      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MAC    = 2'd1,
      ARGMAX = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/fc2_argmax_layer_argmax_seq.sv
// Serial compare-and-hold: start seeds the best pair, each step keeps the
// strictly greater signed value so ties stay on the lower index.
module argmax_seq #(
   parameter int VAL_W = 28,
   parameter int IDX_W = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    step_i,
   input  logic signed [VAL_W-1:0] value_i,
   input  logic        [IDX_W-1:0] index_i,
   output logic        [IDX_W-1:0] best_idx_o,
   output logic signed [VAL_W-1:0] best_val_o
);

   logic        [IDX_W-1:0] best_idx_q, best_idx_d;
   logic signed [VAL_W-1:0] best_val_q, best_val_d;

   always_comb begin
      best_idx_d = best_idx_q;
      best_val_d = best_val_q;
      if (start_i) begin
         best_idx_d = index_i;
         best_val_d = value_i;
      end else if (step_i && (value_i > best_val_q)) begin
         best_idx_d = index_i;
         best_val_d = value_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         best_idx_q <= '0;
         best_val_q <= '0;
      end else begin
         best_idx_q <= best_idx_d;
         best_val_q <= best_val_d;
      end
   end

   assign best_idx_o = best_idx_q;
   assign best_val_o = best_val_q;

endmodule

// File: rtl/fc2_argmax_layer.sv
// 16->10 signed FC layer with bias and serial argmax. Weights/biases stream in
// byte-wise after reset; one input vector in flight at a time.
module fc2_argmax_layer
   import fc2_argmax_layer_pkg::*;
(
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      weight_valid,
   input  logic [W_W-1:0]            filter,
   output logic                      weight_done,
   input  logic                      i_valid,
   input  logic [IN_NUM*IN_W-1:0]    data_in,
   output logic                      in_ready,
   output logic                      o_valid,
   output logic [IDX_W-1:0]          class_out,
   output logic signed [ACC_W-1:0]   max_score
);

   localparam logic [CNT_W-1:0] W_NUM_C  = CNT_W'(W_NUM);
   localparam logic [CNT_W-1:0] WB_LAST  = CNT_W'(WB_TOTAL - 1);
   localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(IN_NUM - 1);
   localparam logic [IDX_W-1:0] J_LAST   = IDX_W'(OUT_NUM - 1);

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         wcnt_q;
   logic                     done_q;
   logic signed [W_W-1:0]    wmem_q [W_NUM];
   logic signed [W_W-1:0]    bmem_q [OUT_NUM];
   logic signed [IN_W-1:0]   in_buf_q [IN_NUM];
   logic signed [ACC_W-1:0]  acc_q [OUT_NUM];
   logic [IDX_W-1:0]         k_q, j_q;
   logic                     o_valid_q;
   logic [IDX_W-1:0]         class_q;
   logic signed [ACC_W-1:0]  score_q;

   logic signed [PROD_W-1:0] prod     [OUT_NUM];
   logic signed [ACC_W-1:0]  acc_mac  [OUT_NUM];
   logic signed [ACC_W-1:0]  acc_bias [OUT_NUM];
   logic [CNT_W-1:0]         boff;
   logic                     accept, am_start, am_step;
   logic signed [ACC_W-1:0]  am_value;
   logic [IDX_W-1:0]         am_index, best_idx;
   logic signed [ACC_W-1:0]  best_val;

   assign in_ready = done_q && (state_q == IDLE);
   assign accept   = i_valid && in_ready;
   assign boff     = wcnt_q - W_NUM_C;

   // Weight/bias stream: output-major weights first, then one bias per class.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wcnt_q <= '0;
         done_q <= 1'b0;
         for (int i = 0; i < W_NUM; i++)   wmem_q[i] <= '0;
         for (int i = 0; i < OUT_NUM; i++) bmem_q[i] <= '0;
      end else if (weight_valid && !done_q) begin
         if (wcnt_q < W_NUM_C) wmem_q[wcnt_q[WIDX_W-1:0]] <= filter;
         else                  bmem_q[boff[IDX_W-1:0]]    <= filter;
         wcnt_q <= wcnt_q + 1'b1;
         if (wcnt_q == WB_LAST) done_q <= 1'b1;
      end
   end

   // Ten parallel MAC lanes; products sign-extended into the accumulator.
   always_comb begin
      for (int o = 0; o < OUT_NUM; o++) begin
         prod[o]     = in_buf_q[k_q] * wmem_q[WIDX_W'(o*IN_NUM) + {{(WIDX_W-IDX_W){1'b0}}, k_q}];
         acc_mac[o]  = acc_q[o] + {{(ACC_W-PROD_W){prod[o][PROD_W-1]}}, prod[o]};
         acc_bias[o] = {{(ACC_W-W_W-BIAS_SHIFT){bmem_q[o][W_W-1]}}, bmem_q[o], {BIAS_SHIFT{1'b0}}};
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)         state_d = MAC;
         MAC:     if (k_q == K_LAST)  state_d = ARGMAX;
         ARGMAX:  if (j_q == J_LAST)  state_d = DONE;
         DONE:                        state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // The argmax seed takes lane 0's post-MAC value on the last MAC edge.
   assign am_start = (state_q == MAC) && (k_q == K_LAST);
   assign am_step  = (state_q == ARGMAX);
   assign am_value = am_start ? acc_mac[0] : acc_q[j_q];
   assign am_index = am_start ? '0 : j_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         k_q       <= '0;
         j_q       <= '0;
         o_valid_q <= 1'b0;
         class_q   <= '0;
         score_q   <= '0;
         for (int i = 0; i < IN_NUM; i++)  in_buf_q[i] <= '0;
         for (int o = 0; o < OUT_NUM; o++) acc_q[o]    <= '0;
      end else begin
         state_q   <= state_d;
         o_valid_q <= (state_q == DONE);
         case (state_q)
            IDLE: if (accept) begin
               for (int i = 0; i < IN_NUM; i++)  in_buf_q[i] <= data_in[i*IN_W +: IN_W];
               for (int o = 0; o < OUT_NUM; o++) acc_q[o]    <= acc_bias[o];
               k_q <= '0;
            end
            MAC: begin
               for (int o = 0; o < OUT_NUM; o++) acc_q[o] <= acc_mac[o];
               k_q <= k_q + 1'b1;
               j_q <= IDX_W'(1);
            end
            ARGMAX: j_q <= j_q + 1'b1;
            DONE: begin
               class_q <= best_idx;
               score_q <= best_val;
            end
            default: ;
         endcase
      end
   end

   argmax_seq #(.VAL_W(ACC_W), .IDX_W(IDX_W)) u_argmax (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .start_i    (am_start),
      .step_i     (am_step),
      .value_i    (am_value),
      .index_i    (am_index),
      .best_idx_o (best_idx),
      .best_val_o (best_val)
   );

   assign weight_done = done_q;
   assign o_valid     = o_valid_q;
   assign class_out   = class_q;
   assign max_score   = score_q;

endmodule

// File: tb/tb_fc2_argmax_layer.sv
// Directed bench for fc2_argmax_layer: weight load, argmax cases, dropped
// inputs, latency and asynchronous reset abort.
module tb_fc2_argmax_layer;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b0;
   logic         weight_valid = 1'b0;
   logic [7:0]   filter = '0;
   logic         weight_done;
   logic         i_valid = 1'b0;
   logic [255:0] data_in = '0;
   logic         in_ready;
   logic         o_valid;
   logic [3:0]   class_out;
   logic [27:0]  max_score;

   int nerr = 0;
   int nchk = 0;
   int pulses;
   logic [7:0] wb [170];

   fc2_argmax_layer dut (
      .i_clk(i_clk), .i_rst(i_rst), .weight_valid(weight_valid), .filter(filter),
      .weight_done(weight_done), .i_valid(i_valid), .data_in(data_in),
      .in_ready(in_ready), .o_valid(o_valid), .class_out(class_out),
      .max_score(max_score)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      #2;
      i_rst = 1'b0;
      tick();
   endtask

   task automatic fill(input logic [7:0] w, input logic [7:0] b);
      for (int i = 0; i < 160; i++) wb[i] = w;
      for (int i = 160; i < 170; i++) wb[i] = b;
   endtask

   task automatic load(input string tag, input bit last_ivalid);
      for (int i = 0; i < 170; i++) begin
         weight_valid = 1'b1;
         filter = wb[i];
         if (i == 169) begin
            i_valid = last_ivalid;
            chk({tag, "_done_before_last"}, 32'(weight_done), 0);
            chk({tag, "_ready_before_last"}, 32'(in_ready), 0);
         end
         tick();
      end
      weight_valid = 1'b0;
      i_valid = 1'b0;
      chk({tag, "_done"}, 32'(weight_done), 1);
      chk({tag, "_ready"}, 32'(in_ready), 1);
   endtask

   function automatic logic [255:0] pack_all(input logic [15:0] v);
      logic [255:0] d;
      for (int k = 0; k < 16; k++) d[k*16 +: 16] = v;
      return d;
   endfunction

   // Capture edge is edge 1; the result must appear only after edge 27.
   task automatic run(input string tag, input logic [255:0] d, input int exp_cls, input int exp_score);
      data_in = d;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      data_in = pack_all(16'd7);
      pulses = 0;
      for (int e = 2; e <= 26; e++) begin
         i_valid = (e == 5);
         tick();
         if (o_valid) pulses++;
      end
      i_valid = 1'b0;
      chk({tag, "_early_valid"}, pulses, 0);
      tick();
      chk({tag, "_valid"}, 32'(o_valid), 1);
      chk({tag, "_ready_again"}, 32'(in_ready), 1);
      chk({tag, "_class"}, 32'(class_out), exp_cls);
      chk({tag, "_score"}, 32'($signed(max_score)), exp_score);
      tick();
      chk({tag, "_pulse_end"}, 32'(o_valid), 0);
      chk({tag, "_class_hold"}, 32'(class_out), exp_cls);
      pulses = 0;
      for (int e = 0; e < 30; e++) begin
         tick();
         if (o_valid) pulses++;
      end
      chk({tag, "_no_extra_valid"}, pulses, 0);
   endtask

   initial begin
      i_rst = 1'b1;
      #12;
      chk("rst_done", 32'(weight_done), 0);
      chk("rst_ovalid", 32'(o_valid), 0);
      chk("rst_class", 32'(class_out), 0);
      chk("rst_score", 32'(max_score), 0);
      chk("rst_ready", 32'(in_ready), 0);
      i_rst = 1'b0;
      tick();

      // i_valid before weights are loaded is dropped
      data_in = pack_all(16'd256);
      i_valid = 1'b1;
      tick(); tick(); tick();
      i_valid = 1'b0;
      pulses = 0;
      for (int e = 0; e < 35; e++) begin
         tick();
         if (o_valid) pulses++;
      end
      chk("preload_drop", pulses, 0);

      // all weights 1, biases 0; i_valid alongside the last byte is dropped
      fill(8'd1, 8'd0);
      load("ld1", 1'b1);
      pulses = 0;
      for (int e = 0; e < 35; e++) begin
         tick();
         if (o_valid) pulses++;
      end
      chk("lastbyte_drop", pulses, 0);
      run("tie", pack_all(16'd256), 0, 4096);

      // row 3 doubled: 16*100*2
      do_reset();
      fill(8'd1, 8'd0);
      for (int k = 0; k < 16; k++) wb[3*16 + k] = 8'd2;
      load("ld2", 1'b0);
      run("row3", pack_all(16'd100), 3, 3200);

      // only bias[7]=1 -> 1<<8
      do_reset();
      fill(8'd0, 8'd0);
      wb[160 + 7] = 8'd1;
      load("ld3", 1'b0);
      run("bias7", pack_all(16'd1234), 7, 256);

      // signed: row 2 = +1, others -1 -> 1600 vs -1600
      do_reset();
      fill(8'hFF, 8'd0);
      for (int k = 0; k < 16; k++) wb[2*16 + k] = 8'd1;
      load("ld4", 1'b0);
      run("signed", pack_all(16'd100), 2, 1600);

      // reset asserted in ARGMAX aborts and forgets weights
      data_in = pack_all(16'd100);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      for (int e = 2; e <= 20; e++) tick();
      #2;
      i_rst = 1'b1;
      #1;
      chk("abort_ovalid", 32'(o_valid), 0);
      chk("abort_class", 32'(class_out), 0);
      chk("abort_score", 32'(max_score), 0);
      chk("abort_done", 32'(weight_done), 0);
      #3;
      i_rst = 1'b0;
      tick();
      i_valid = 1'b1;
      pulses = 0;
      for (int e = 0; e < 40; e++) begin
         tick();
         if (o_valid) pulses++;
      end
      i_valid = 1'b0;
      chk("abort_no_valid", pulses, 0);
      chk("abort_ready", 32'(in_ready), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
